// File: rtl/ctr_cmd_pkg.sv
// ---------------------------------------------------------------------------
// ctr_cmd_pkg
// Shared definitions for the counter command sequencer: command opcodes,
// sequencer state encodings and the packed command-word width.
// A command word is packed as {op[1:0], cnt[CW-1:0], data[N-1:0]}.
// ---------------------------------------------------------------------------
package ctr_cmd_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_UP   = 2'b00;
    localparam op_t OP_DOWN = 2'b01;
    localparam op_t OP_LOAD = 2'b10;
    localparam op_t OP_CLR  = 2'b11;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EXEC = 1'b1;

    // Width of one queued command word for a given data width and count width.
    function automatic int cmd_word_w(input int n, input int cw);
        return 2 + cw + n;
    endfunction

    // COUNT_UP and COUNT_DOWN are the only ops whose duration comes from cnt.
    function automatic logic is_count(input op_t op);
        return (op == OP_UP) || (op == OP_DOWN);
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// ---------------------------------------------------------------------------
// cmd_fifo
// Small synchronous FIFO holding queued command words. The head entry is
// presented combinationally on rd_data so the sequencer can decode and pop it
// in the same cycle.
// Ports:
//   clk      rising-edge clock
//   reset    synchronous active-low reset (empties the FIFO)
//   flush    synchronous flush; empties the FIFO, overrides push/pop
//   push     write wr_data (ignored when full)
//   wr_data  command word to write
//   pop      discard head entry (ignored when empty)
//   rd_data  current head entry
//   full     DEPTH entries held
//   empty    no entries held
// ---------------------------------------------------------------------------
module cmd_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are log2(DEPTH) bits, so they wrap modulo DEPTH naturally.
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);

endmodule

// File: rtl/ctr_cmd_seq.sv
// ---------------------------------------------------------------------------
// ctr_cmd_seq
// Command sequencer driving the control pins of an up/down counter. Commands
// (COUNT_UP, COUNT_DOWN, LOAD, CLEAR) are queued through a valid/ready port and
// executed back-to-back with cycle-exact durations. hold pauses execution,
// abort flushes the queue and the running command.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   cmd_valid  command offered;  cmd_ready  command accepted on valid&ready
//   cmd_op     00 up, 01 down, 10 load, 11 clear
//   cmd_cnt    cycle count for count ops;  cmd_data  value for load
//   hold       pause execution;  abort  flush queue and current command
//   en/up/load/syn_clr  counter strobes;  d  load data (sticky)
//   busy       command executing or queued
//   done       one-cycle pulse when the last queued command finishes
// ---------------------------------------------------------------------------
module ctr_cmd_seq
    import ctr_cmd_pkg::*;
#(
    parameter int N     = 8,
    parameter int CW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [CW-1:0] cmd_cnt,
    input  logic [N-1:0]  cmd_data,
    input  logic          hold,
    input  logic          abort,
    output logic          en,
    output logic          up,
    output logic          load,
    output logic          syn_clr,
    output logic [N-1:0]  d,
    output logic          busy,
    output logic          done
);

    localparam int CMD_W = cmd_word_w(N, CW);

    logic             fifo_full, fifo_empty;
    logic             push, pop, start;
    logic [CMD_W-1:0] head;
    op_t              head_op;
    logic [CW-1:0]    head_cnt;
    logic [N-1:0]     head_data;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    rem_q, rem_d;
    logic             en_q, en_d, up_q, up_d, ld_q, ld_d, clr_q, clr_d;
    logic             done_q, done_d;
    logic [N-1:0]     d_q, d_d;

    // Ready depends only on occupancy, abort and reset so a source may wait on
    // it before raising valid without forming a combinational loop.
    assign cmd_ready = !fifo_full && !abort && reset;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = start;

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (abort),
        .push    (push),
        .wr_data ({cmd_op, cmd_cnt, cmd_data}),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign {head_op, head_cnt, head_data} = head;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        en_d    = en_q;
        up_d    = up_q;
        ld_d    = ld_q;
        clr_d   = clr_q;
        d_d     = d_q;
        done_d  = 1'b0;
        start   = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
            en_d    = 1'b0;
            up_d    = 1'b0;
            ld_d    = 1'b0;
            clr_d   = 1'b0;
        end else if (state_q == ST_IDLE) begin
            start = !fifo_empty && !hold;
        end else if (!hold) begin
            // rem_q counts the cycles still to execute including this one;
            // 0 only occurs for a zero-length count, which is a single slot.
            if (rem_q > CW'(1)) begin
                rem_d = rem_q - CW'(1);
            end else if (!fifo_empty) begin
                start = 1'b1;
            end else begin
                state_d = ST_IDLE;
                en_d    = 1'b0;
                up_d    = 1'b0;
                ld_d    = 1'b0;
                clr_d   = 1'b0;
                done_d  = 1'b1;
            end
        end

        if (start) begin
            state_d = ST_EXEC;
            rem_d   = is_count(head_op) ? head_cnt : CW'(1);
            en_d    = is_count(head_op) && (head_cnt != '0);
            up_d    = (head_op == OP_UP) && (head_cnt != '0);
            ld_d    = (head_op == OP_LOAD);
            clr_d   = (head_op == OP_CLR);
            if (head_op == OP_LOAD) d_d = head_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            en_q    <= 1'b0;
            up_q    <= 1'b0;
            ld_q    <= 1'b0;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            en_q    <= en_d;
            up_q    <= up_d;
            ld_q    <= ld_d;
            clr_q   <= clr_d;
            done_q  <= done_d;
            d_q     <= d_d;
        end
    end

    // A held cycle is not an executed cycle: the strobes are masked in that
    // very cycle and rem_q stays frozen, so the strobe count is unaffected.
    assign en      = en_q  && !hold;
    assign up      = up_q  && !hold;
    assign load    = ld_q  && !hold;
    assign syn_clr = clr_q && !hold;
    assign d       = d_q;
    assign done    = done_q;
    assign busy    = (state_q == ST_EXEC) || !fifo_empty;

endmodule

// File: tb/tb_ctr_cmd_seq.sv
`timescale 1ns/1ps
module tb_ctr_cmd_seq;

    localparam logic [1:0] OP_UP   = 2'b00;
    localparam logic [1:0] OP_DOWN = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    logic       clk = 1'b0;
    logic       reset, cmd_valid, cmd_ready, hold, abort;
    logic [1:0] cmd_op;
    logic [7:0] cmd_cnt, cmd_data;
    logic       en, up, load, syn_clr, busy, done;
    logic [7:0] d;

    always #5 clk = ~clk;

    ctr_cmd_seq #(.N(8), .CW(8), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_cnt   (cmd_cnt),
        .cmd_data  (cmd_data),
        .hold      (hold),
        .abort     (abort),
        .en        (en),
        .up        (up),
        .load      (load),
        .syn_clr   (syn_clr),
        .d         (d),
        .busy      (busy),
        .done      (done)
    );

    // The counter being controlled; its final value is compared with the
    // value computed arithmetically from the command list.
    logic [7:0] tb_cnt;
    always_ff @(posedge clk) begin
        if (!reset)       tb_cnt <= 8'd0;
        else if (syn_clr) tb_cnt <= 8'd0;
        else if (load)    tb_cnt <= d;
        else if (en)      tb_cnt <= up ? tb_cnt + 8'd1 : tb_cnt - 8'd1;
    end

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] cnt;
        logic [7:0] data;
    } cmd_t;

    typedef struct packed {
        logic       en;
        logic       up;
        logic       ld;
        logic       clr;
        logic [7:0] d;
    } slot_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_d;
    logic [7:0] exp_val;
    cmd_t       cmd_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input slot_t e, input logic e_done, input logic e_busy);
        chk({tag, ".en"},   32'(en),      32'(e.en));
        chk({tag, ".up"},   32'(up),      32'(e.up));
        chk({tag, ".load"}, 32'(load),    32'(e.ld));
        chk({tag, ".clr"},  32'(syn_clr), 32'(e.clr));
        chk({tag, ".d"},    32'(d),       32'(e.d));
        chk({tag, ".done"}, 32'(done),    32'(e_done));
        chk({tag, ".busy"}, 32'(busy),    32'(e_busy));
    endtask

    task automatic add_cmd(input logic [1:0] op, input logic [7:0] cnt, input logic [7:0] data);
        cmd_t c;
        c.op   = op;
        c.cnt  = cnt;
        c.data = data;
        cmd_q.push_back(c);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pushes cmd_q as fast as ready allows and checks every cycle against the
    // expected strobe stream: each count op expands to cnt slots (one empty
    // slot when cnt is 0), load and clear to one slot each; commands run
    // back-to-back, a held cycle shows no strobes and consumes no slot, and
    // done follows the last slot.
    task automatic run_stream(input string name, input int hold_pct, input int hs_pos, input int hs_len);
        slot_t      stream[$];
        slot_t      s;
        slot_t      z;
        logic [7:0] dcur;
        int         phase, pos, pidx, hcnt, cyc;
        logic       h, acc;

        dcur = exp_d;
        foreach (cmd_q[i]) begin
            s   = '0;
            s.d = dcur;
            case (cmd_q[i].op)
                OP_UP, OP_DOWN: begin
                    if (cmd_q[i].cnt == 8'd0) begin
                        stream.push_back(s);
                    end else begin
                        s.en = 1'b1;
                        s.up = (cmd_q[i].op == OP_UP);
                        repeat (int'(cmd_q[i].cnt)) stream.push_back(s);
                        exp_val = s.up ? exp_val + cmd_q[i].cnt : exp_val - cmd_q[i].cnt;
                    end
                end
                OP_LOAD: begin
                    dcur    = cmd_q[i].data;
                    s.d     = dcur;
                    s.ld    = 1'b1;
                    stream.push_back(s);
                    exp_val = dcur;
                end
                default: begin
                    s.clr   = 1'b1;
                    stream.push_back(s);
                    exp_val = 8'd0;
                end
            endcase
        end

        phase = 0;
        pos   = 0;
        pidx  = 0;
        hcnt  = 0;
        for (cyc = 0; cyc < 1000 && phase < 4; cyc++) begin
            cmd_valid = (pidx < cmd_q.size());
            if (cmd_valid) begin
                cmd_op   = cmd_q[pidx].op;
                cmd_cnt  = cmd_q[pidx].cnt;
                cmd_data = cmd_q[pidx].data;
            end
            h = 1'b0;
            if (phase == 2) begin
                if (pos == hs_pos && hcnt < hs_len) begin
                    h = 1'b1;
                    hcnt++;
                end else if (int'($urandom_range(99)) < hold_pct) begin
                    h = 1'b1;
                end
            end
            hold = h;
            @(negedge clk);
            z = '0;
            case (phase)
                0: begin
                    z.d = exp_d;
                    chk_out($sformatf("%s.c%0d", name, cyc), z, 1'b0, 1'b0);
                end
                1: begin
                    z.d = exp_d;
                    chk_out($sformatf("%s.c%0d", name, cyc), z, 1'b0, 1'b1);
                end
                2: begin
                    z = stream[pos];
                    if (h) begin
                        z.en  = 1'b0;
                        z.up  = 1'b0;
                        z.ld  = 1'b0;
                        z.clr = 1'b0;
                    end
                    chk_out($sformatf("%s.c%0d", name, cyc), z, 1'b0, 1'b1);
                end
                default: begin
                    z.d = dcur;
                    chk_out($sformatf("%s.c%0d", name, cyc), z, 1'b1, 1'b0);
                end
            endcase
            acc = cmd_valid && cmd_ready;
            step();
            if (acc) pidx++;
            case (phase)
                0: if (acc) phase = 1;
                1: phase = 2;
                2: if (!h) begin
                    pos++;
                    if (pos == stream.size()) phase = 3;
                end
                default: phase = 4;
            endcase
        end
        hold      = 1'b0;
        cmd_valid = 1'b0;
        exp_d     = dcur;
        chk({name, ".finished"}, 32'(phase == 4), 32'd1);
        chk({name, ".counter"},  32'(tb_cnt),     32'(exp_val));
        $display("stream %s: %0d cmds, %0d slots, %0d cycles", name, cmd_q.size(), stream.size(), cyc);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not terminate");
    end

    initial begin
        int   n_en;
        logic seen_done;

        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_cnt   = 8'd0;
        cmd_data  = 8'd0;
        hold      = 1'b0;
        abort     = 1'b0;
        exp_d     = 8'd0;
        exp_val   = 8'd0;

        // Reset state.
        repeat (3) step();
        @(negedge clk);
        chk_out("reset", slot_t'(0), 1'b0, 1'b0);
        chk("reset.ready", 32'(cmd_ready), 32'd0);
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("reset.ready_after", 32'(cmd_ready), 32'd1);
        step();

        // Single long count.
        cmd_q.delete();
        add_cmd(OP_UP, 8'd12, 8'h00);
        run_stream("up12", 0, -1, 0);

        // Mixed back-to-back sequence.
        cmd_q.delete();
        add_cmd(OP_UP,   8'd12, 8'h00);
        add_cmd(OP_DOWN, 8'd6,  8'h00);
        add_cmd(OP_LOAD, 8'd0,  8'h03);
        add_cmd(OP_UP,   8'd2,  8'h00);
        add_cmd(OP_CLR,  8'd0,  8'h00);
        add_cmd(OP_UP,   8'd3,  8'h00);
        run_stream("mix", 0, -1, 0);
        chk("mix.final3", 32'(tb_cnt), 32'd3);

        // Zero-length count then clear.
        cmd_q.delete();
        add_cmd(OP_UP,  8'd0, 8'h00);
        add_cmd(OP_CLR, 8'd0, 8'h00);
        run_stream("zero_clr", 0, -1, 0);

        // Hold for 3 cycles after the 4th enable of UP 10.
        cmd_q.delete();
        add_cmd(OP_UP, 8'd10, 8'h00);
        run_stream("hold", 0, 4, 3);

        // Queue fills while held; 5th push waits for the first pop.
        hold      = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = OP_UP;
        cmd_cnt   = 8'd3;
        cmd_data  = 8'h00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("full.ready%0d", i), 32'(cmd_ready), 32'(i < 4));
            chk($sformatf("full.en%0d", i),    32'(en),        32'd0);
            step();
        end
        hold = 1'b0;
        @(negedge clk);
        chk("full.ready_pop_edge", 32'(cmd_ready), 32'd0);
        chk("full.busy",           32'(busy),      32'd1);
        step();
        @(negedge clk);
        chk("full.ready_after_pop", 32'(cmd_ready), 32'd1);
        chk("full.first_en",        32'(en),        32'd1);
        step();
        cmd_valid = 1'b0;
        n_en      = 1;
        seen_done = 1'b0;
        for (int i = 0; i < 40 && !seen_done; i++) begin
            @(negedge clk);
            if (en) n_en++;
            if (done) seen_done = 1'b1;
            step();
        end
        chk("full.en_total", 32'(n_en),      32'd15);
        chk("full.done",     32'(seen_done), 32'd1);
        exp_val = exp_val + 8'd15;
        chk("full.counter",  32'(tb_cnt),    32'(exp_val));

        // Abort during the 5th enable of UP 10 with two commands queued.
        n_en = 0;
        for (int i = 0; i < 30 && n_en < 5; i++) begin
            cmd_valid = (i < 3);
            cmd_op    = (i == 0) ? OP_UP : (i == 1) ? OP_UP : OP_CLR;
            cmd_cnt   = (i == 0) ? 8'd10 : 8'd2;
            @(negedge clk);
            if (en) n_en++;
            if (n_en == 5) begin
                abort     = 1'b1;
                cmd_valid = 1'b1;
                cmd_op    = OP_LOAD;
                cmd_data  = 8'hEE;
                #1;
                chk("abort.ready", 32'(cmd_ready), 32'd0);
            end
            step();
        end
        chk("abort.reached", 32'(n_en), 32'd5);
        abort     = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk_out("abort.next", slot_t'({4'b0000, exp_d}), 1'b0, 1'b0);
        step();
        @(negedge clk);
        chk_out("abort.later", slot_t'({4'b0000, exp_d}), 1'b0, 1'b0);
        step();
        exp_val = exp_val + 8'd5;
        chk("abort.counter", 32'(tb_cnt), 32'(exp_val));

        // Randomized command streams with random hold.
        for (int r = 0; r < 4; r++) begin
            int n;
            cmd_q.delete();
            n = int'($urandom_range(8, 3));
            for (int k = 0; k < n; k++) begin
                add_cmd(2'($urandom_range(3)), 8'($urandom_range(6)), 8'($urandom));
            end
            run_stream($sformatf("rnd%0d", r), 25, -1, 0);
        end

        // Reset in the middle of a count.
        n_en = 0;
        for (int i = 0; i < 30 && n_en < 3; i++) begin
            cmd_valid = (i < 2);
            cmd_op    = (i == 0) ? OP_LOAD : OP_UP;
            cmd_cnt   = 8'd10;
            cmd_data  = 8'hA5;
            @(negedge clk);
            if (en) n_en++;
            if (n_en == 3) reset = 1'b0;
            step();
        end
        chk("rst_mid.reached", 32'(n_en), 32'd3);
        cmd_valid = 1'b0;
        exp_d     = 8'd0;
        exp_val   = 8'd0;
        chk_out("rst_mid.after", slot_t'(0), 1'b0, 1'b0);
        chk("rst_mid.ready", 32'(cmd_ready), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk_out("rst_mid.released", slot_t'(0), 1'b0, 1'b0);
        step();

        // Life after reset.
        cmd_q.delete();
        add_cmd(OP_LOAD, 8'd0, 8'h11);
        add_cmd(OP_DOWN, 8'd3, 8'h00);
        run_stream("post_rst", 0, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
